uart_alu_intf: RTL

UART_ALU_INTF -- requirements
Module: uart_alu_intf

---
 rtl/uart_alu_intf.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_intf.sv
// ---------------------------------------------------------------------------
// uart_alu_intf
//   Frames bytes from a UART rx FIFO into ALU operands and pushes the ALU
//   result into a UART tx FIFO. A frame is three bytes: operand A, operand B,
//   opcode. One cycle after the opcode is taken the combinational ALU result
//   is registered. The result is then pushed as soon as the tx FIFO has room.
//
// Parameters
//   DBIT        data byte width
//   NB_OP       opcode width (NB_OP <= DBIT); opcode = low NB_OP bits of byte
//   TIMEOUT_CYC inter-byte timeout in cycles (only with UART_ALU_TIMEOUT_EN)
//
// Ports
//   clock        single clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_rx_empty   rx FIFO empty flag
//   i_rx_data    rx FIFO head word, valid while i_rx_empty = 0
//   o_rd_uart    rx FIFO pop strobe (combinational)
//   o_data_a     ALU operand A (registered)
//   o_data_b     ALU operand B (registered)
//   o_op         ALU opcode (registered)
//   i_alu_result combinational ALU result
//   i_tx_full    tx FIFO full flag
//   o_wr_uart    tx FIFO push strobe (combinational)
//   o_tx_data    tx FIFO write data (the result register)
//   o_timeout    one-cycle pulse when a partial frame is abandoned
//
// Configuration
//   UART_ALU_TIMEOUT_EN  when defined, a frame stalled in GET_B or GET_OP for
//                        TIMEOUT_CYC cycles is abandoned and the FSM returns
//                        to GET_A. When undefined, GET states wait forever
//                        and o_timeout is tied to 0.
// ---------------------------------------------------------------------------
module uart_alu_intf #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clock,
  input  logic             i_reset_n,
  input  logic             i_rx_empty,
  input  logic [DBIT-1:0]  i_rx_data,
  output logic             o_rd_uart,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_op,
  input  logic [DBIT-1:0]  i_alu_result,
  input  logic             i_tx_full,
  output logic             o_wr_uart,
  output logic [DBIT-1:0]  o_tx_data,
  output logic             o_timeout
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND
  } state_e;

  state_e           state_q, state_d;
  logic [DBIT-1:0]  data_a_q, data_a_d;
  logic [DBIT-1:0]  data_b_q, data_b_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [DBIT-1:0]  result_q, result_d;
  logic             rd_uart, wr_uart;

`ifdef UART_ALU_TIMEOUT_EN
  localparam int              CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    result_d = result_q;
    rd_uart  = 1'b0;
    wr_uart  = 1'b0;
`ifdef UART_ALU_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif

    case (state_q)
      GET_A: begin
        if (!i_rx_empty) begin
          rd_uart  = 1'b1;
          data_a_d = i_rx_data;
          state_d  = GET_B;
        end
      end
      GET_B: begin
        if (!i_rx_empty) begin
          rd_uart  = 1'b1;
          data_b_d = i_rx_data;
          state_d  = GET_OP;
        end
      end
      GET_OP: begin
        if (!i_rx_empty) begin
          rd_uart = 1'b1;
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = i_alu_result;
        state_d  = SEND;
      end
      SEND: begin
        wr_uart = !i_tx_full;
        if (!i_tx_full) state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase

`ifdef UART_ALU_TIMEOUT_EN
    // Only a wait for B or the opcode is timed; a byte present this cycle
    // wins over an expiring count because the count only runs while empty.
    if ((state_q == GET_B || state_q == GET_OP) && i_rx_empty) begin
      if (cnt_q == CNT_MAX) begin
        state_d   = GET_A;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= GET_A;
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

`ifdef UART_ALU_TIMEOUT_EN
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Strobes are gated by reset so the FIFOs never see a pop or push while
  // the block is held in reset, whatever the FIFO flags say.
  assign o_rd_uart = rd_uart && i_reset_n;
  assign o_wr_uart = wr_uart && i_reset_n;
  assign o_data_a  = data_a_q;
  assign o_data_b  = data_b_q;
  assign o_op      = op_q;
  assign o_tx_data = result_q;

endmodule
